// File: rtl/seq_detect_param_if.sv
// Serial detector bus: qualified input bit stream plus match pulse, fill level and match count.
// The producer side uses the master modport; the detector uses slave.
interface seq_detect_param_if #(
  parameter int LEN = 4,
  parameter int CW  = 8
) ();
  logic                       A;
  logic                       B;
  logic                       CLR;
  logic                       Y;
  logic                       Z;
  logic [$clog2(LEN+1)-1:0]   S;
  logic [CW-1:0]              R;

  modport master (output A, output B, output CLR, input Y, input Z, input S, input R);
  modport slave  (input A, input B, input CLR, output Y, output Z, output S, output R);
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: shifts in A whenever B is high, pulses Y when the
// last LEN qualified bits equal PATTERN, and keeps a saturating hit count on R.
module seq_detect_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             OVERLAP = 0,
  parameter int             CW      = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  seq_detect_param_if.slave bus
);
  localparam int SW = $clog2(LEN + 1);
  localparam logic [SW-1:0] FULL = SW'(LEN);

  logic [LEN-1:0] hist_reg;
  logic [LEN-1:0] hist_next;
  logic [SW-1:0]  fill_reg;
  logic [SW-1:0]  fill_inc;
  logic [SW-1:0]  fill_next;
  logic [CW-1:0]  cnt_reg;
  logic           y_reg;
  logic           z_reg;
  logic           hit;

  always_comb begin
    hist_next = {hist_reg[LEN-2:0], bus.A};
    fill_inc  = (fill_reg == FULL) ? fill_reg : fill_reg + 1'b1;
    hit       = (hist_next == PATTERN) && (fill_inc == FULL);
    // Non-overlapping mode throws away the bits that formed the match.
    fill_next = (hit && (OVERLAP == 0)) ? '0 : fill_inc;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist_reg <= '0;
      fill_reg <= '0;
      cnt_reg  <= '0;
      y_reg    <= 1'b0;
      z_reg    <= 1'b0;
    end else if (bus.CLR) begin
      hist_reg <= '0;
      fill_reg <= '0;
      cnt_reg  <= '0;
      y_reg    <= 1'b0;
      z_reg    <= 1'b0;
    end else if (bus.B) begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      z_reg    <= (fill_next != '0);
      y_reg    <= hit;
      if (hit && (cnt_reg != {CW{1'b1}}))
        cnt_reg <= cnt_reg + 1'b1;
    end else begin
      y_reg <= 1'b0;
    end
  end

  assign bus.Y = y_reg;
  assign bus.Z = z_reg;
  assign bus.S = fill_reg;
  assign bus.R = cnt_reg;
endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four variants share one stimulus stream; a behavioural model
// queues expected {Y,Z,S,R} per step and the queue is drained after each clock edge.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, clr = 1'b0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.LEN(4), .CW(8)) ifc0 ();
  seq_detect_param_if #(.LEN(4), .CW(8)) ifc1 ();
  seq_detect_param_if #(.LEN(4), .CW(8)) ifc2 ();
  seq_detect_param_if #(.LEN(4), .CW(2)) ifc3 ();

  assign ifc0.A = a; assign ifc0.B = b; assign ifc0.CLR = clr;
  assign ifc1.A = a; assign ifc1.B = b; assign ifc1.CLR = clr;
  assign ifc2.A = a; assign ifc2.B = b; assign ifc2.CLR = clr;
  assign ifc3.A = a; assign ifc3.B = b; assign ifc3.CLR = clr;

  seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CW(8))
    dut0 (.CLK(clk), .RST_N(rst_n), .bus(ifc0));
  seq_detect_param #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(1), .CW(8))
    dut1 (.CLK(clk), .RST_N(rst_n), .bus(ifc1));
  seq_detect_param #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(0), .CW(8))
    dut2 (.CLK(clk), .RST_N(rst_n), .bus(ifc2));
  seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CW(2))
    dut3 (.CLK(clk), .RST_N(rst_n), .bus(ifc3));

  int n_pass = 0;
  int n_total = 0;

  // Model parameters per variant
  int p_pat [4] = '{11, 10, 10, 11};
  int p_ov  [4] = '{0, 1, 0, 0};
  int p_max [4] = '{255, 255, 255, 3};

  // Model state: list of qualified bits since the last restart, plus count
  int m_bits [4][$];
  int m_r    [4];

  typedef struct { int dut; int exp; } sb_t;
  sb_t sb_q[$];

  function automatic int pack(int y, int z, int s, int r);
    return (y << 20) | (z << 16) | (s << 8) | r;
  endfunction

  function automatic int actual(int d);
    case (d)
      0: return pack(int'(ifc0.Y), int'(ifc0.Z), int'(ifc0.S), int'(ifc0.R));
      1: return pack(int'(ifc1.Y), int'(ifc1.Z), int'(ifc1.S), int'(ifc1.R));
      2: return pack(int'(ifc2.Y), int'(ifc2.Z), int'(ifc2.S), int'(ifc2.R));
      default: return pack(int'(ifc3.Y), int'(ifc3.Z), int'(ifc3.S), int'(ifc3.R));
    endcase
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 4; d++) begin
      m_bits[d].delete();
      m_r[d] = 0;
    end
    sb_q.delete();
  endfunction

  function automatic int model_step(int d, bit ai, bit bi, bit ci);
    int y;
    int tail;
    y = 0;
    if (ci) begin
      m_bits[d].delete();
      m_r[d] = 0;
    end else if (bi) begin
      m_bits[d].push_back(int'(ai));
      if (m_bits[d].size() > 4) void'(m_bits[d].pop_front());
      if (m_bits[d].size() == 4) begin
        tail = m_bits[d][0] * 8 + m_bits[d][1] * 4 + m_bits[d][2] * 2 + m_bits[d][3];
        if (tail == p_pat[d]) begin
          y = 1;
          if (m_r[d] < p_max[d]) m_r[d]++;
          if (p_ov[d] == 0) m_bits[d].delete();
        end
      end
    end
    return pack(y, (m_bits[d].size() != 0) ? 1 : 0, m_bits[d].size(), m_r[d]);
  endfunction

  task automatic step(bit ai, bit bi, bit ci);
    sb_t e;
    int got;
    a = ai; b = bi; clr = ci;
    for (int d = 0; d < 4; d++) begin
      e.dut = d;
      e.exp = model_step(d, ai, bi, ci);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      got = actual(e.dut);
      n_total++;
      if (got !== e.exp)
        $display("FAIL sb dut%0d a=%0b b=%0b clr=%0b: got %06h want %06h", e.dut, ai, bi, ci, got, e.exp);
      else
        n_pass++;
    end
    $display("step a=%0b b=%0b clr=%0b -> Y=%0b%0b%0b%0b S0=%0d R0=%0d", ai, bi, ci,
             ifc0.Y, ifc1.Y, ifc2.Y, ifc3.Y, ifc0.S, ifc0.R);
    a = 1'b0; b = 1'b0; clr = 1'b0;
  endtask

  task automatic send_bits(int bits [], bit gap);
    foreach (bits[i]) begin
      step(bits[i][0], 1'b1, 1'b0);
      if (gap) step(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (actual(d) !== 0) $display("FAIL async_reset dut%0d: got %06h want 000000", d, actual(d));
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset pulse applied");
  endtask

  task automatic test_reset();
    #12;
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (actual(d) !== 0) $display("FAIL reset_state dut%0d: got %06h want 000000", d, actual(d));
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    n_total++;
    if (ifc0.Y !== 1'b1 || ifc0.R !== 8'd1 || ifc0.S !== 3'd0 || ifc0.Z !== 1'b0)
      $display("FAIL basic_hit: got Y=%0b R=%0d S=%0d Z=%0b want Y=1 R=1 S=0 Z=0", ifc0.Y, ifc0.R, ifc0.S, ifc0.Z);
    else n_pass++;
    step(0, 0, 0);
    n_total++;
    if (ifc0.Y !== 1'b0) $display("FAIL basic_pulse_width: got Y=%0b want 0", ifc0.Y);
    else n_pass++;
  endtask

  task automatic test_overlap();
    step(0, 0, 1);
    send_bits('{1, 0, 1, 0, 1, 0}, 1'b0);
    n_total++;
    if (ifc1.R !== 8'd2) $display("FAIL overlap_count: got %0d want 2", ifc1.R);
    else n_pass++;
    n_total++;
    if (ifc2.R !== 8'd1 || ifc2.S !== 3'd2)
      $display("FAIL nonoverlap_end: got R=%0d S=%0d want R=1 S=2", ifc2.R, ifc2.S);
    else n_pass++;
  endtask

  task automatic test_idle_gaps();
    step(0, 0, 1);
    send_bits('{1, 0, 1}, 1'b1);
    step(1, 1, 0);
    n_total++;
    if (ifc0.Y !== 1'b1 || ifc0.R !== 8'd1)
      $display("FAIL idle_gap_hit: got Y=%0b R=%0d want Y=1 R=1", ifc0.Y, ifc0.R);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int want_r [5] = '{1, 2, 3, 3, 3};
    int pulses = 0;
    step(0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
      if (ifc3.Y === 1'b1) pulses++;
      n_total++;
      if (int'(ifc3.R) !== want_r[k]) $display("FAIL saturate_r%0d: got %0d want %0d", k, ifc3.R, want_r[k]);
      else n_pass++;
    end
    n_total++;
    if (pulses !== 5) $display("FAIL saturate_pulses: got %0d want 5", pulses);
    else n_pass++;
  endtask

  task automatic test_clr_on_hit();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
    step(1, 1, 1);
    n_total++;
    if (ifc0.Y !== 1'b0 || ifc0.R !== 8'd0 || ifc0.S !== 3'd0)
      $display("FAIL clr_on_hit: got Y=%0b R=%0d S=%0d want Y=0 R=0 S=0", ifc0.Y, ifc0.R, ifc0.S);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sequence();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
    async_reset();
    step(1, 1, 0);
    n_total++;
    if (ifc0.Y !== 1'b0 || ifc0.S !== 3'd1 || ifc0.Z !== 1'b1)
      $display("FAIL reset_mid_seq: got Y=%0b S=%0d Z=%0b want Y=0 S=1 Z=1", ifc0.Y, ifc0.S, ifc0.Z);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overlap();
    test_idle_gaps();
    test_saturate();
    test_clr_on_hit();
    test_reset_mid_sequence();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
